// File: rtl/counter_updown_mod.sv
// Up/down counter with programmable modulo limit and step, wrap or saturate mode,
// clamped load, a selectable threshold comparator and registered event pulses.
module counter_updown_mod #(
  parameter int unsigned N      = 8,
  parameter int unsigned STEP_W = 4
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              enable,
  input  logic              dec,
  input  logic              load,
  input  logic [N-1:0]      load_value,
  input  logic [STEP_W-1:0] step,
  input  logic [N-1:0]      limit,
  input  logic              sat_mode,
  input  logic [N-1:0]      thr_value,
  input  logic [1:0]        thr_mode,
  output logic [N-1:0]      count,
  output logic              threshold,
  output logic              thr_rise,
  output logic              wrap_pulse,
  output logic              at_zero,
  output logic              at_limit
);

  typedef enum logic [1:0] {
    THR_GT = 2'b00,
    THR_GE = 2'b01,
    THR_EQ = 2'b10,
    THR_LT = 2'b11
  } thr_mode_t;

  logic [N:0]   cnt_x;
  logic [N:0]   lim_x;
  logic [N:0]   lim1;
  logic [N:0]   step_x;
  logic [N:0]   s;
  logic [N:0]   sum;
  logic [N:0]   wrap_up;
  logic [N:0]   wrap_dn;
  logic [N-1:0] next_count;
  logic         next_wrap;
  logic         thr_q;
  thr_mode_t    mode;

  // All step arithmetic is N+1 bits wide so limit+1 and count+s never overflow.
  assign cnt_x   = {1'b0, count};
  assign lim_x   = {1'b0, limit};
  assign lim1    = lim_x + 1'b1;
  assign step_x  = {{(N + 1 - STEP_W){1'b0}}, step};
  assign s       = (step_x > lim1) ? lim1 : step_x;
  assign sum     = cnt_x + s;
  assign wrap_up = sum - lim1;
  assign wrap_dn = cnt_x + lim1 - s;

  always_comb begin
    next_count = count;
    next_wrap  = 1'b0;
    if (load) begin
      next_count = (load_value > limit) ? limit : load_value;
    end else if (count > limit) begin
      next_count = limit;
    end else if (enable && (s != '0)) begin
      if (!dec) begin
        if (sum <= lim_x) begin
          next_count = sum[N-1:0];
        end else begin
          next_count = sat_mode ? limit : wrap_up[N-1:0];
          next_wrap  = 1'b1;
        end
      end else begin
        if (cnt_x >= s) begin
          next_count = cnt_x[N-1:0] - s[N-1:0];
        end else begin
          next_count = sat_mode ? '0 : wrap_dn[N-1:0];
          next_wrap  = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      count      <= '0;
      wrap_pulse <= 1'b0;
      thr_q      <= 1'b1;
    end else begin
      count      <= next_count;
      wrap_pulse <= next_wrap;
      thr_q      <= threshold;
    end
  end

  assign mode = thr_mode_t'(thr_mode);

  always_comb begin
    threshold = 1'b0;
    case (mode)
      THR_GT:  threshold = (count >  thr_value);
      THR_GE:  threshold = (count >= thr_value);
      THR_EQ:  threshold = (count == thr_value);
      THR_LT:  threshold = (count <  thr_value);
      default: threshold = 1'b0;
    endcase
  end

  assign thr_rise = threshold & ~thr_q;
  assign at_zero  = (count == '0);
  assign at_limit = (count == limit);

endmodule
